cda_tdc_avg: RTL and testbench



---
 rtl/cda_tdc_avg.sv | 115 +++++++++++
 tb/tb_cda_tdc_avg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cda_tdc_avg.sv
// cda_tdc_avg: averaging delay-line TDC measuring the lag from an x2 rise to the next x1 rise
module cda_tdc_avg #(
    parameter int STAGES   = 87,
    parameter int OUT_W    = 7,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x1,
    input  logic             x2,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             overflow,
    output logic             missed
);
    localparam int ACC_W = OUT_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] N = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            nxt;
    logic [STAGES-1:0] hist;
    logic [STAGES:0]   v;
    logic              x1_q;
    logic              x1_edge;
    logic              ovf_s;
    logic              take;
    logic              load;
    logic              miss;
    logic              clr;
    logic [OUT_W-1:0]  d;
    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] cnt;
    logic [AVG_LOG2:0] cnt_inc;
    logic              ovf_acc;

    assign v       = {hist, x2};
    assign x1_edge = x1 & ~x1_q;
    assign cnt_inc = cnt + 1'b1;

    // lag = position of the most recent x2 rise in the history; none in the window is an overflow sample
    always_comb begin
        d     = OUT_W'(STAGES);
        ovf_s = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--)
            if (v[k] & ~v[k+1]) begin
                d     = OUT_W'(k);
                ovf_s = 1'b0;
            end
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= nxt;

    // next state: dropping en always returns to IDLE and discards any pending work
    always_comb
        nxt = !en            ? IDLE :
              state == IDLE  ? RUN :
              state == RUN   ? ((take && cnt_inc == N) ? DONE : RUN) :
              state == DONE  ? (load ? RUN : DONE) : IDLE;

    // control strobes decoded from the current state
    always_comb begin
        take = en && state == RUN && x1_edge;
        load = en && state == DONE && (!out_valid || out_ready);
        miss = en && state == DONE && x1_edge;
        clr  = state == IDLE || load;
    end

    // x2 history, x1 edge reference and sample accumulation
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hist    <= '0;
            x1_q    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else begin
            x1_q <= x1;
            if (en)
                hist <= {hist[STAGES-2:0], x2};
            if (clr) begin
                acc     <= '0;
                cnt     <= '0;
                ovf_acc <= 1'b0;
            end else if (take) begin
                acc     <= acc + ACC_W'(d);
                cnt     <= cnt_inc;
                ovf_acc <= ovf_acc | ovf_s;
            end
        end

    // result register with valid/ready handshake; a load on a handshake edge replaces the old result
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            missed    <= 1'b0;
        end else begin
            if (load) begin
                out      <= OUT_W'(acc >> AVG_LOG2);
                overflow <= ovf_acc;
            end
            out_valid <= load | (out_valid & ~out_ready);
            missed    <= missed | miss;
        end
endmodule

// File: tb/tb_cda_tdc_avg.sv
// tb_cda_tdc_avg: directed and random stimulus against an event-timestamp reference model
module tb_cda_tdc_avg;
    localparam int STAGES   = 87;
    localparam int OUT_W    = 7;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;

    typedef struct {int o; bit f;} res_t;

    logic clk = 0;
    logic rst = 1;
    logic en = 0;
    logic x1 = 0;
    logic x2 = 0;
    logic out_ready = 0;
    logic [OUT_W-1:0] out;
    logic out_valid;
    logic overflow;
    logic missed;

    int checks = 0;
    int errors = 0;

    int ec, last_rise, m_ph, m_sum, m_cnt, m_out;
    bit m_ov, m_x1q, m_px2, m_v, m_ovf_o, m_missed;
    bit s_v, s_ovf;
    int s_out;
    res_t got_q[$];

    always #5 clk = ~clk;

    cda_tdc_avg #(.STAGES(STAGES), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2)) dut (
        .clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2), .out_ready(out_ready),
        .out(out), .out_valid(out_valid), .overflow(overflow), .missed(missed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ec = 0; last_rise = -100000; m_ph = 0; m_sum = 0; m_cnt = 0; m_out = 0;
        m_ov = 0; m_x1q = 0; m_px2 = 0; m_v = 0; m_ovf_o = 0; m_missed = 0;
    endtask

    // lag counted in enabled clock edges between the latest x2 rise and the x1 rise
    task automatic model_step();
        bit e1, o, ld;
        int lag;
        e1 = x1 && !m_x1q;
        m_x1q = x1;
        if (en) begin
            ec++;
            if (x2 && !m_px2) last_rise = ec;
            m_px2 = x2;
        end
        o = (ec - last_rise) > STAGES - 1;
        lag = o ? STAGES : ec - last_rise;
        ld = 0;
        if (!en) m_ph = 0;
        else if (m_ph == 0) begin
            m_sum = 0; m_cnt = 0; m_ov = 0; m_ph = 1;
        end else if (m_ph == 1) begin
            if (e1) begin
                m_sum += lag; m_cnt++; m_ov |= o;
                if (m_cnt == N) m_ph = 2;
            end
        end else begin
            if (e1) m_missed = 1;
            if (!m_v || out_ready) begin
                ld = 1; m_out = m_sum / N; m_ovf_o = m_ov;
                m_sum = 0; m_cnt = 0; m_ov = 0; m_ph = 1;
            end
        end
        if (ld) m_v = 1;
        else if (out_ready) m_v = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (s_v && out_ready) got_q.push_back('{s_out, s_ovf});
            model_step();
            @(negedge clk);
            s_v = out_valid; s_out = int'(out); s_ovf = overflow;
            check("out_valid", out_valid, m_v);
            check("out", out, m_out);
            check("overflow", overflow, m_ovf_o);
            check("missed", missed, m_missed);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_missed", missed, 0);
        model_reset();
        s_v = 0;
        got_q.delete();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic pair(input int lag);
        x2 = 1;
        x1 = (lag == 0);
        tick(lag == 0 ? 1 : lag);
        if (lag > 0) begin
            x1 = 1;
            tick(1);
        end
        x1 = 0;
        x2 = 0;
        tick(3);
    endtask

    task automatic x1_pulse();
        x1 = 1;
        tick(1);
        x1 = 0;
        tick(3);
    endtask

    task automatic expect_res(input string tag, input int o, input bit f);
        res_t r;
        tick(3);
        check({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            check({tag, "_out"}, r.o, o);
            check({tag, "_ovf"}, r.f, f);
        end
        got_q.delete();
    endtask

    initial begin
        model_reset();
        s_v = 0; s_out = 0; s_ovf = 0;
        do_reset();
        en = 1; out_ready = 1;
        tick(3);
        repeat (4) x1_pulse();
        expect_res("stuck_low", 87, 1);
        repeat (4) pair(5);
        expect_res("const5", 5, 0);
        pair(3); pair(4); pair(4); pair(6);
        expect_res("mixed", 4, 0);
        pair(0); pair(0); pair(0); pair(86);
        expect_res("edges", 21, 0);
        repeat (4) pair(87);
        expect_res("lag87", 87, 1);
        pair(86); pair(86); pair(86); pair(87);
        expect_res("near_lim", 86, 1);
        out_ready = 0;
        repeat (4) pair(7);
        repeat (4) pair(9);
        pair(3);
        check("bp_missed", missed, 1);
        check("bp_held", out, 7);
        out_ready = 1;
        tick(1);
        out_ready = 0;
        check("bp_reload_out", out, 9);
        check("bp_reload_valid", out_valid, 1);
        check("bp_r1_count", got_q.size(), 1);
        if (got_q.size() > 0) check("bp_r1_out", got_q[0].o, 7);
        got_q.delete();
        out_ready = 1;
        expect_res("bp_r2", 9, 0);
        pair(20); pair(20);
        en = 0;
        tick(3);
        en = 1;
        tick(2);
        repeat (4) pair(10);
        expect_res("en_drop", 10, 0);
        out_ready = 0;
        repeat (4) pair(12);
        pair(12); pair(12);
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        out_ready = 1;
        tick(2);
        x1_pulse();
        repeat (3) pair(2);
        expect_res("post_rst", 23, 1);
        for (int i = 0; i < 4000; i++) begin
            en = $urandom_range(0, 99) < 98;
            out_ready = $urandom_range(0, 99) < 70;
            if ($urandom_range(0, 99) < 4) x2 = ~x2;
            if ($urandom_range(0, 99) < 12) x1 = ~x1;
            tick(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
